// File: rtl/abr_mpram_lat_if.sv
// Request/response bundle for the abr_mpram_lat multi-port register-file RAM.
interface abr_mpram_lat_if #(
  parameter int DEPTH        = 64,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_LANES    = 4,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 2,
  parameter int ADDR_WIDTH   = $clog2(DEPTH)
);
  logic                                           zeroize_i;
  logic                                           zeroize_busy_o;
  logic [NUM_WR_PORTS-1:0]                        we_i;
  logic [NUM_WR_PORTS-1:0][NUM_LANES-1:0]         wstrb_i;
  logic [NUM_WR_PORTS-1:0][ADDR_WIDTH-1:0]        waddr_i;
  logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0]        wdata_i;
  logic [NUM_RD_PORTS-1:0]                        re_i;
  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0]        raddr_i;
  logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]        rdata_o;
  logic [NUM_RD_PORTS-1:0]                        rvalid_o;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]               reg_o;

  modport master (
    output zeroize_i, we_i, wstrb_i, waddr_i, wdata_i, re_i, raddr_i,
    input  zeroize_busy_o, rdata_o, rvalid_o, reg_o
  );
  modport slave (
    input  zeroize_i, we_i, wstrb_i, waddr_i, wdata_i, re_i, raddr_i,
    output zeroize_busy_o, rdata_o, rvalid_o, reg_o
  );
endinterface

// File: rtl/abr_mpram_lat.sv
// Multi-port lane-strobed register-file RAM with 1/2-cycle read latency and a strided zeroize sweep.
// Optional macro ABR_RAM_WR_BYPASS_EN forwards same-cycle write data to matching reads.

module abr_mpram_rd_port #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  re,
  input  logic                  kill,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);
  logic [RD_LAT:1]                 vld_q;
  logic [RD_LAT:1][DATA_WIDTH-1:0] dat_q;
  logic [RD_LAT:0]                 vld_pipe;
  logic [RD_LAT:0][DATA_WIDTH-1:0] dat_pipe;

  assign vld_pipe = {vld_q, re};
  assign dat_pipe = {dat_q, din};

  // kill zeroes beats moving while a sweep is active or about to start
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      for (int s = 1; s <= RD_LAT; s++) begin
        vld_q[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_q[s] <= kill ? '0 : dat_pipe[s-1];
      end
    end
  end

  assign rdata  = dat_q[RD_LAT];
  assign rvalid = vld_q[RD_LAT];
endmodule

module abr_mpram_lat #(
  parameter int DEPTH        = 64,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_LANES    = 4,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 2,
  parameter int RD_LAT       = 1,
  parameter int ZERO_STRIDE  = 8,
  parameter int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst_b,
  abr_mpram_lat_if.slave bus
);
  localparam int LANE_W  = DATA_WIDTH / NUM_LANES;
  localparam int NUM_BLK = DEPTH / ZERO_STRIDE;
  localparam int CNT_W   = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [CNT_W-1:0]    LAST_BLK = CNT_W'(NUM_BLK - 1);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("abr_mpram_lat: RD_LAT must be 1 or 2");
  end
  if (DATA_WIDTH % NUM_LANES != 0) begin : g_bad_lanes
    $error("abr_mpram_lat: DATA_WIDTH must be a multiple of NUM_LANES");
  end
  if (DEPTH % ZERO_STRIDE != 0) begin : g_bad_stride
    $error("abr_mpram_lat: DEPTH must be a multiple of ZERO_STRIDE");
  end

  typedef enum logic {IDLE, SWEEP} zstate_e;

  zstate_e                            state, state_nxt;
  logic [CNT_W-1:0]                   cnt, cnt_nxt;
  logic                               sweep;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]   mem;
  logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_row;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_A);
  endfunction

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (bus.zeroize_i) begin
        state_nxt = SWEEP;
        cnt_nxt   = '0;
      end
      SWEEP: begin
        if (bus.zeroize_i)        cnt_nxt = '0;
        else if (cnt == LAST_BLK) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else                  cnt_nxt = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sweep              = (state == SWEEP);
  assign bus.zeroize_busy_o = sweep;

  // Ports applied in ascending order so the highest index wins a shared lane.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem <= '0;
    end else if (sweep) begin
      for (int r = 0; r < DEPTH; r++)
        if (CNT_W'(r / ZERO_STRIDE) == cnt) mem[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR_PORTS; p++)
        for (int l = 0; l < NUM_LANES; l++)
          if (bus.we_i[p] && bus.wstrb_i[p][l] && in_range(bus.waddr_i[p]))
            mem[bus.waddr_i[p]][l*LANE_W +: LANE_W] <= bus.wdata_i[p][l*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    rd_row = '0;
    for (int q = 0; q < NUM_RD_PORTS; q++) begin
      if (!sweep && in_range(bus.raddr_i[q])) begin
        rd_row[q] = mem[bus.raddr_i[q]];
`ifdef ABR_RAM_WR_BYPASS_EN
        for (int p = 0; p < NUM_WR_PORTS; p++)
          for (int l = 0; l < NUM_LANES; l++)
            if (bus.we_i[p] && bus.wstrb_i[p][l] && bus.waddr_i[p] == bus.raddr_i[q])
              rd_row[q][l*LANE_W +: LANE_W] = bus.wdata_i[p][l*LANE_W +: LANE_W];
`endif
      end
    end
  end

  for (genvar q = 0; q < NUM_RD_PORTS; q++) begin : g_rd
    abr_mpram_rd_port #(.DATA_WIDTH(DATA_WIDTH), .RD_LAT(RD_LAT)) u_rd (
      .clk    (clk),
      .rst_b  (rst_b),
      .re     (bus.re_i[q]),
      .kill   (sweep | bus.zeroize_i),
      .din    (rd_row[q]),
      .rdata  (bus.rdata_o[q]),
      .rvalid (bus.rvalid_o[q])
    );
  end

  assign bus.reg_o = mem;
endmodule

// File: tb/tb_abr_mpram_lat.sv
// Directed bench: identical stimulus to an RD_LAT=1 and an RD_LAT=2 instance of abr_mpram_lat.
module tb_abr_mpram_lat;
  logic clk, rst_b, zeroize;
  logic [1:0]       we, re;
  logic [1:0][3:0]  wstrb;
  logic [1:0][5:0]  waddr, raddr;
  logic [1:0][31:0] wdata;
  int checks = 0, failures = 0, nb, guard;

  abr_mpram_lat_if #(.DEPTH(64), .DATA_WIDTH(32), .NUM_LANES(4), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2)) b1 ();
  abr_mpram_lat_if #(.DEPTH(64), .DATA_WIDTH(32), .NUM_LANES(4), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2)) b2 ();

  assign b1.zeroize_i = zeroize; assign b2.zeroize_i = zeroize;
  assign b1.we_i = we;           assign b2.we_i = we;
  assign b1.wstrb_i = wstrb;     assign b2.wstrb_i = wstrb;
  assign b1.waddr_i = waddr;     assign b2.waddr_i = waddr;
  assign b1.wdata_i = wdata;     assign b2.wdata_i = wdata;
  assign b1.re_i = re;           assign b2.re_i = re;
  assign b1.raddr_i = raddr;     assign b2.raddr_i = raddr;

  abr_mpram_lat #(.DEPTH(64), .DATA_WIDTH(32), .NUM_LANES(4), .NUM_RD_PORTS(2),
                  .NUM_WR_PORTS(2), .RD_LAT(1), .ZERO_STRIDE(8)) u1 (.clk(clk), .rst_b(rst_b), .bus(b1));
  abr_mpram_lat #(.DEPTH(64), .DATA_WIDTH(32), .NUM_LANES(4), .NUM_RD_PORTS(2),
                  .NUM_WR_PORTS(2), .RD_LAT(2), .ZERO_STRIDE(8)) u2 (.clk(clk), .rst_b(rst_b), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    zeroize = 1'b0; we = '0; wstrb = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
  endtask

  task automatic wr(input int p, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    we[p] = 1'b1; waddr[p] = a; wdata[p] = d; wstrb[p] = s;
  endtask

  task automatic rd(input int p, input logic [5:0] a);
    re[p] = 1'b1; raddr[p] = a;
  endtask

  initial begin
    idle();
    rst_b = 1'b0;
    re = 2'b11; zeroize = 1'b1; wr(0, 6'd1, 32'hFFFF_FFFF, 4'hF);
    repeat (2) tick();
    chk("rst_busy",    32'(b1.zeroize_busy_o), 32'd0);
    chk("rst_rvalid1", 32'(b1.rvalid_o),       32'd0);
    chk("rst_rvalid2", 32'(b2.rvalid_o),       32'd0);
    chk("rst_rdata",   b2.rdata_o[0],          32'd0);
    chk("rst_regs",    32'(|b1.reg_o),         32'd0);
    idle();
    #2 rst_b = 1'b1;
    tick();

    // basic write then read, latency 1 vs 2
    wr(0, 6'd5, 32'hDEAD_BEEF, 4'hF);
    tick();
    chk("wr_row5", b1.reg_o[5], 32'hDEAD_BEEF);
    idle(); rd(0, 6'd5);
    tick();
    chk("lat1_valid", 32'(b1.rvalid_o[0]), 32'd1);
    chk("lat1_data",  b1.rdata_o[0],       32'hDEAD_BEEF);
    chk("lat2_early", 32'(b2.rvalid_o[0]), 32'd0);
    idle();
    tick();
    chk("lat2_valid", 32'(b2.rvalid_o[0]), 32'd1);
    chk("lat2_data",  b2.rdata_o[0],       32'hDEAD_BEEF);
    chk("lat1_drop",  32'(b1.rvalid_o[0]), 32'd0);
    chk("lat1_hold",  b1.rdata_o[0],       32'hDEAD_BEEF);

    // lane strobes, merge, priority, zero strobe
    wr(0, 6'd3, 32'h1122_3344, 4'hF);
    tick();
    idle();
    wr(0, 6'd3, 32'hAAAA_AAAA, 4'b0011); wr(1, 6'd3, 32'hBBBB_BBBB, 4'b0110);
    tick();
    chk("lane_merge", b1.reg_o[3], 32'h11BB_BBAA);
    idle();
    wr(0, 6'd4, 32'h0101_0101, 4'hF); wr(1, 6'd4, 32'h0202_0202, 4'hF);
    tick();
    chk("port_prio", b2.reg_o[4], 32'h0202_0202);
    idle();
    wr(0, 6'd5, 32'h0, 4'h0);
    tick();
    chk("strb_zero", b1.reg_o[5], 32'hDEAD_BEEF);

    // read during write
    idle(); wr(0, 6'd7, 32'h1, 4'hF);
    tick();
    idle(); wr(0, 6'd7, 32'h2, 4'hF); rd(1, 6'd7);
    tick();
`ifdef ABR_RAM_WR_BYPASS_EN
    chk("rdw_lat1", b1.rdata_o[1], 32'h2);
`else
    chk("rdw_lat1", b1.rdata_o[1], 32'h1);
`endif
    chk("rdw_valid", 32'(b1.rvalid_o[1]), 32'd1);
    idle();
    tick();
`ifdef ABR_RAM_WR_BYPASS_EN
    chk("rdw_lat2", b2.rdata_o[1], 32'h2);
`else
    chk("rdw_lat2", b2.rdata_o[1], 32'h1);
`endif
    chk("rdw_row7", b1.reg_o[7], 32'h2);

    // full fill then zeroize sweep
    for (int i = 0; i < 32; i++) begin
      idle();
      wr(0, 6'(2*i), 32'hFFFF_FFFF, 4'hF); wr(1, 6'(2*i+1), 32'hFFFF_FFFF, 4'hF);
      tick();
    end
    idle();
    chk("fill_all", 32'(&b1.reg_o), 32'd1);
    zeroize = 1'b1;
    tick();
    chk("zbusy_start", 32'(b1.zeroize_busy_o), 32'd1);
    idle(); wr(0, 6'd60, 32'h1234_5678, 4'hF); rd(0, 6'd8);
    tick();
    chk("zclr_row0",  b1.reg_o[0], 32'd0);
    chk("zclr_row7",  b1.reg_o[7], 32'd0);
    chk("zkeep_row8", b1.reg_o[8], 32'hFFFF_FFFF);
    chk("zrd_valid",  32'(b1.rvalid_o[0]), 32'd1);
    chk("zrd_data",   b1.rdata_o[0], 32'd0);
    re = '0;
    nb = 2; guard = 0;
    while (b1.zeroize_busy_o && guard < 20) begin
      tick(); guard++;
      if (b1.zeroize_busy_o) nb++;
    end
    idle();
    chk("zbusy_cycles", 32'(nb), 32'd8);
    chk("zall_clear",   32'(|b1.reg_o), 32'd0);
    chk("zwr_dropped",  b1.reg_o[60], 32'd0);

    // in-flight read killed by sweep entry, then restart at sweep cycle 4
    wr(0, 6'd9, 32'hCAFE_F00D, 4'hF);
    tick();
    idle(); rd(0, 6'd9);
    tick();
    idle();
    tick();
    chk("pre_lat2_data", b2.rdata_o[0], 32'hCAFE_F00D);
    rd(0, 6'd9);
    tick();
    idle(); zeroize = 1'b1;
    tick();
    chk("flight_valid", 32'(b2.rvalid_o[0]), 32'd1);
    chk("flight_data",  b2.rdata_o[0], 32'd0);
    zeroize = 1'b0;
    repeat (3) tick();
    chk("pre_restart_busy", 32'(b2.zeroize_busy_o), 32'd1);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    nb = b2.zeroize_busy_o ? 1 : 0; guard = 0;
    while (b2.zeroize_busy_o && guard < 20) begin
      tick(); guard++;
      if (b2.zeroize_busy_o) nb++;
    end
    chk("restart_cycles", 32'(nb), 32'd8);

    // async reset in the middle of a sweep
    idle(); wr(0, 6'd20, 32'hA5A5_A5A5, 4'hF);
    tick();
    idle(); zeroize = 1'b1;
    tick();
    zeroize = 1'b0; rd(0, 6'd20); rd(1, 6'd20);
    tick();
    chk("mid_row20", b1.reg_o[20], 32'hA5A5_A5A5);
    #2 rst_b = 1'b0;
    #1;
    chk("arst_busy",  32'(b1.zeroize_busy_o), 32'd0);
    chk("arst_row20", b2.reg_o[20], 32'd0);
    chk("arst_rv2",   32'(b2.rvalid_o), 32'd0);
    idle();
    tick();
    #2 rst_b = 1'b1;
    repeat (2) tick();
    chk("post_rv1",   32'(b1.rvalid_o), 32'd0);
    chk("post_rv2",   32'(b2.rvalid_o), 32'd0);
    chk("post_busy",  32'(b2.zeroize_busy_o), 32'd0);
    chk("post_regs",  32'(|b2.reg_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
